sipo_packer: RTL and testbench

SIPO_PACKER -- requirements
Module: sipo_packer

---
 rtl/sipo_packer.sv | 88 ++++++++
 tb/tb_sipo_packer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sipo_packer.sv
// Serial-in, parallel-out packer: gathers DEPTH narrow symbols (first symbol in
// the LSBs) into one wide word held in a valid/ready output register.
module sipo_packer #(
    parameter int SIZE_DATA_IN  = 2,
    parameter int SIZE_DATA_OUT = 16,
    parameter int DEPTH         = SIZE_DATA_OUT / SIZE_DATA_IN,
    parameter int SIZE_DEPTH    = $clog2(DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic [SIZE_DATA_IN-1:0]  i_data,
    output logic                     o_ready,
    input  logic                     i_flush,
    output logic [SIZE_DATA_OUT-1:0] o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [SIZE_DEPTH-1:0]    o_count,
    output logic                     o_done
);

    localparam logic [SIZE_DEPTH-1:0] LAST = SIZE_DEPTH'(DEPTH - 1);

    logic [SIZE_DEPTH-1:0]    r_count;
    logic [SIZE_DATA_OUT-1:0] r_partial;
    logic [SIZE_DATA_OUT-1:0] r_data;
    logic                     r_valid;
    logic                     r_done;

    logic                     w_last;
    logic                     w_accept;
    logic                     w_load;
    logic                     w_drain;
    logic [SIZE_DATA_OUT-1:0] w_word;

    assign w_last   = (r_count == LAST);
    assign o_ready  = ~w_last | ~r_valid | i_ready;
    assign w_accept = i_valid & o_ready & ~i_flush;
    assign w_load   = w_accept & w_last;
    assign w_drain  = r_valid & i_ready;

    // Unwritten partial bits are always zero, so inserting the current symbol
    // into its slot yields the complete word on the last accept.
    always_comb begin
        w_word = r_partial;
        w_word[int'(r_count) * SIZE_DATA_IN +: SIZE_DATA_IN] = i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count   <= '0;
            r_partial <= '0;
        end else if (i_flush) begin
            r_count   <= '0;
            r_partial <= '0;
        end else if (w_load) begin
            r_count   <= '0;
            r_partial <= '0;
        end else if (w_accept) begin
            r_count   <= r_count + 1'b1;
            r_partial <= w_word;
        end
    end

    // Output register is cleared on drain so o_data reads zero while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_done  = r_done;

endmodule

// File: tb/tb_sipo_packer.sv
// Directed and randomized bench for sipo_packer; a queue-based packing model
// predicts every output each cycle.
module tb_sipo_packer;

    localparam int W     = 2;
    localparam int WO    = 16;
    localparam int DEPTH = WO / W;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic [W-1:0]  i_data = '0;
    logic          o_ready;
    logic          i_flush = 1'b0;
    logic [WO-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [2:0]    o_count;
    logic          o_done;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0]  q[$];
    logic          m_valid = 1'b0;
    logic [WO-1:0] m_data  = '0;
    logic          m_done  = 1'b0;
    int            m_words = 0;
    int            seen_done = 0;

    sipo_packer #(.SIZE_DATA_IN(W), .SIZE_DATA_OUT(WO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .i_flush(i_flush), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_count(o_count), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WO-1:0] pack_word();
        int unsigned acc = 0;
        for (int k = 0; k < DEPTH; k++) acc += int'(q[k]) * (1 << (W * k));
        return WO'(acc);
    endfunction

    task automatic check_outputs();
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        chk("o_data",  32'(o_data),  32'(m_data));
        chk("o_count", 32'(o_count), 32'(q.size()));
        chk("o_done",  32'(o_done),  32'(m_done));
        if (o_done) seen_done++;
    endtask

    // One clock: drive at negedge, check o_ready, advance model, check outputs.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        logic exp_ready, acc, ld;
        logic [WO-1:0] word;
        i_valid = v; i_data = d; i_flush = f; i_ready = r;
        #1;
        exp_ready = (q.size() != DEPTH - 1) || !m_valid || r;
        chk("o_ready", 32'(o_ready), 32'(exp_ready));
        acc  = v && exp_ready && !f;
        ld   = 1'b0;
        word = '0;
        if (f) q.delete();
        else if (acc) begin
            q.push_back(d);
            if (q.size() == DEPTH) begin
                ld = 1'b1;
                word = pack_word();
                q.delete();
            end
        end
        if (ld) begin
            m_valid = 1'b1; m_data = word; m_words++;
        end else if (m_valid && r) begin
            m_valid = 1'b0; m_data = '0;
        end
        m_done = ld;
        @(posedge i_clk);
        @(negedge i_clk);
        check_outputs();
    endtask

    task automatic mid_reset();
        i_rst_n = 1'b0;
        #1;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data",  32'(o_data),  32'd0);
        chk("rst_o_count", 32'(o_count), 32'd0);
        chk("rst_o_done",  32'(o_done),  32'd0);
        chk("rst_o_ready", 32'(o_ready), 32'd1);
        q.delete(); m_valid = 1'b0; m_data = '0; m_done = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        int start, budget;
        logic [W-1:0] pat;
        repeat (2) @(negedge i_clk);
        chk("reset_o_valid", 32'(o_valid), 32'd0);
        chk("reset_o_data",  32'(o_data),  32'd0);
        chk("reset_o_count", 32'(o_count), 32'd0);
        chk("reset_o_ready", 32'(o_ready), 32'd1);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Back-to-back 00,01,10,11 x2 -> E4E4
        for (int k = 0; k < 8; k++) begin
            pat = W'(k % 4);
            cyc(1'b1, pat, 1'b0, 1'b1);
        end
        chk("e4e4_data", 32'(o_data), 32'hE4E4);
        chk("e4e4_done", 32'(o_done), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("e4e4_drained", 32'(o_valid), 32'd0);

        // Back-pressure: word 1 held, seven accepted, then drain+load together
        for (int k = 0; k < 8; k++) cyc(1'b1, 2'b01, 1'b0, 1'b0);
        chk("bp_word1", 32'(o_data), 32'h5555);
        for (int k = 0; k < 8; k++) cyc(1'b1, 2'b10, 1'b0, 1'b0);
        chk("bp_count7", 32'(o_count), 32'd7);
        chk("bp_word1_hold", 32'(o_data), 32'h5555);
        cyc(1'b1, 2'b11, 1'b0, 1'b1);
        chk("bp_word2", 32'(o_data), 32'hEAAA);
        chk("bp_valid", 32'(o_valid), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Flush after three symbols
        for (int k = 0; k < 3; k++) cyc(1'b1, 2'b10, 1'b0, 1'b1);
        cyc(1'b1, 2'b01, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) cyc(1'b1, 2'b11, 1'b0, 1'b0);
        chk("flush_word", 32'(o_data), 32'hFFFF);

        // Reset mid-word with a word pending
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) cyc(1'b1, 2'b01, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 2'b10, 1'b0, 1'b0);
        mid_reset();
        for (int k = 0; k < 8; k++) cyc(1'b1, W'(k % 4), 1'b0, 1'b1);
        chk("post_reset_word", 32'(o_data), 32'hE4E4);
        m_words = 0; seen_done = 0;

        // Random gaps, occasional flush, 1000 words
        start = m_words;
        budget = 0;
        while (m_words < start + 1000 && budget < 60000) begin
            cyc($urandom_range(3) != 0, W'($urandom), $urandom_range(199) == 0,
                $urandom_range(3) != 0);
            budget++;
        end
        chk("random_budget", 32'(budget < 60000), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("done_count", 32'(seen_done), 32'(m_words));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
